debounce_multi: RTL
===================

# debounce_multi

Parametrised N-channel switch debouncer with edge-event outputs. Each channel filters a raw mechanical input: the debounced level changes only after the raw level has differed from it for COUNTER_LIMIT consecutive clocks. A one-clock rise or fall pulse is issued on each accepted change. The block sits between board-level buttons/switches and user logic, replacing per-switch single-channel debouncers.

## Interface
- NUM_CHANNELS, 4: number of independent switch channels (≥1).
- COUNTER_LIMIT, 250000: consecutive differing clocks required to accept a change (≥1); 10 ms at 25 MHz.
- INIT_VALUE, {NUM_CHANNELS{1'b0}}: reset value of each debounced level, one bit per channel.
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_switch  input  NUM_CHANNELS  raw switch levels, asynchronous to i_clk.
- o_switch  output  NUM_CHANNELS  debounced levels.
- o_rise  output  NUM_CHANNELS  one-clock pulse per channel on an accepted 0→1 change.
- o_fall  output  NUM_CHANNELS  one-clock pulse per channel on an accepted 1→0 change.
- o_any_event  output  1  OR of all o_rise and o_fall bits, registered with them.

## Operation
- Per channel: counter of width $clog2(COUNTER_LIMIT+1), stable level `stable`, and a sampled input `samp`. `samp` is the synchroniser output when DEBOUNCE_SYNC_EN is set, else i_switch directly.
- Each clock, per channel:
  - samp == stable: counter ← 0; no event.
  - samp != stable and counter < COUNTER_LIMIT−1: counter ← counter+1.
  - samp != stable and counter == COUNTER_LIMIT−1: stable ← samp, counter ← 0. Assert o_rise (if samp = 1) or o_fall (if samp = 0) for exactly the next clock.
- Any cycle where samp matches stable restarts the count from zero. Glitches shorter than COUNTER_LIMIT clocks never propagate.
- COUNTER_LIMIT = 1: a change is accepted on the first clock samp differs.
- Counter never exceeds COUNTER_LIMIT−1, so there is no wrap-around.
- Channels are fully independent. Simultaneous acceptances on several channels produce simultaneous pulses; o_any_event asserts once for that cycle.
- Reset (asynchronous assert, synchronous release via i_clk):
  - counters ← 0, stable ← INIT_VALUE, o_rise/o_fall/o_any_event ← 0, synchroniser flops ← INIT_VALUE.
  - Reset mid-count discards the partial count. No event is generated on reset release, even if i_switch ≠ INIT_VALUE. That difference must then survive a full COUNTER_LIMIT window.

## Timing
- o_switch is registered and equals stable.
- From the first clock samp differs (and stays differing): o_switch updates at the COUNTER_LIMIT-th rising edge. o_rise/o_fall are high in the same cycle o_switch first shows the new value.
- With DEBOUNCE_SYNC_EN: 2 extra clocks from i_switch to samp. Total latency is COUNTER_LIMIT+2 edges.
- Event pulses are exactly one clock wide. A channel cannot produce another event for at least COUNTER_LIMIT clocks after one.

## Configuration
- DEBOUNCE_SYNC_EN defined: a 2-flop synchroniser per channel (reset to INIT_VALUE) precedes the filter. Latency is +2 clocks. Required whenever i_switch comes from pins.
- DEBOUNCE_SYNC_EN undefined: i_switch feeds the filter directly. Only for inputs already synchronous to i_clk.

## Structure
- Shared package debounce_pkg holds:
  - default COUNTER_LIMIT constant;
  - counter-width function (clog2 of limit+1);
  - synchroniser depth constant (2).
- One sub-module, debounce_channel: sync (conditional), counter, stable level and edge pulses for a single bit. debounce_multi instantiates NUM_CHANNELS copies in a generate loop and ORs the events into o_any_event.

## Test plan
Bench uses NUM_CHANNELS=4, COUNTER_LIMIT=8, INIT_VALUE=4'b0000, and is run with and without DEBOUNCE_SYNC_EN.
- Reset: hold i_rst_n=0 with i_switch=4'b1111 → o_switch=0000 and no pulses. After release, o_switch=1111 exactly 8 (+2 with sync) edges later, with o_rise=1111 and o_any_event=1 for one clock.
- Glitch reject: ch0 pulses high for 7 clocks then low → o_switch[0] stays 0, no o_rise.
- Bounce: ch1 toggles 1,0,1,0 every 3 clocks, then holds 1 → o_switch[1] rises 8 clocks after the final hold starts, with a single o_rise[1].
- Fall: ch2 stable 1, drop to 0 for 8 clocks → o_fall[2] one clock wide, coincident with o_switch[2]=0; o_rise[2] stays 0.
- Simultaneous: ch0 and ch3 change together → o_rise[0], o_rise[3] in the same cycle, o_any_event high for one clock only.
- Reset mid-count: ch1 differs for 5 clocks, assert i_rst_n=0 for 1 clock → counter cleared, o_switch[1]=0. The change is accepted only 8 clocks after release.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel switch debouncer.
package debounce_pkg;

  localparam int DEFAULT_COUNTER_LIMIT = 250000;
  localparam int SYNC_DEPTH            = 2;

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debounce filter: optional input synchroniser (DEBOUNCE_SYNC_EN),
// consecutive-difference counter, stable level and one-clock edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   COUNTER_LIMIT = DEFAULT_COUNTER_LIMIT,
  parameter logic INIT_VALUE    = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_switch,
  output logic o_switch,
  output logic o_rise,
  output logic o_fall,
  output logic o_event_next
);

  localparam int                CNT_W    = cnt_width(COUNTER_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COUNTER_LIMIT - 1);

  logic             samp;
  logic             stable;
  logic [CNT_W-1:0] cnt;

`ifdef DEBOUNCE_SYNC_EN
  logic [SYNC_DEPTH-1:0] sync_p;

  // stage boundary: raw pin -> synchronised sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_p <= {SYNC_DEPTH{INIT_VALUE}};
    end else begin
      sync_p <= {sync_p[SYNC_DEPTH-2:0], i_switch};
    end
  end

  assign samp = sync_p[SYNC_DEPTH-1];
`else
  assign samp = i_switch;
`endif

  // Fires on the clock where the differing run reaches its full length.
  assign o_event_next = (samp != stable) && (cnt == CNT_LAST);

  // stage boundary: sample -> filtered level and edge pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      stable <= INIT_VALUE;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      if (samp == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= samp;
        cnt    <= '0;
        o_rise <= samp;
        o_fall <= ~samp;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign o_switch = stable;

endmodule

// File: rtl/debounce_multi.sv
// N-channel switch debouncer with per-channel rise/fall pulses and a combined event flag.
// Build option: define DEBOUNCE_SYNC_EN to insert a 2-flop synchroniser per channel.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int                      NUM_CHANNELS  = 4,
  parameter int                      COUNTER_LIMIT = DEFAULT_COUNTER_LIMIT,
  parameter logic [NUM_CHANNELS-1:0] INIT_VALUE    = {NUM_CHANNELS{1'b0}}
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_CHANNELS-1:0] i_switch,
  output logic [NUM_CHANNELS-1:0] o_switch,
  output logic [NUM_CHANNELS-1:0] o_rise,
  output logic [NUM_CHANNELS-1:0] o_fall,
  output logic                    o_any_event
);

  logic [NUM_CHANNELS-1:0] event_next;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    debounce_channel #(
      .COUNTER_LIMIT (COUNTER_LIMIT),
      .INIT_VALUE    (INIT_VALUE[g])
    ) u_chan (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_switch     (i_switch[g]),
      .o_switch     (o_switch[g]),
      .o_rise       (o_rise[g]),
      .o_fall       (o_fall[g]),
      .o_event_next (event_next[g])
    );
  end

  // Registered from the same next-cycle condition so it aligns with the pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_any_event <= 1'b0;
    end else begin
      o_any_event <= |event_next;
    end
  end

endmodule
